// File: rtl/tdm_demux41_if.sv
// Bus bundle between a TDM source and the tdm_demux41 receiver.
// The par_err signal exists only when DEMUX_PARITY_EN is defined.
interface tdm_demux41_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] din;
  logic             en;
  logic             fsync;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             frame_vld;
  logic             locked;
  logic             sync_err;
  logic [2:0]       slot;
`ifdef DEMUX_PARITY_EN
  logic             par_err;
`endif

  // The master drives the TDM stream and observes the recovered channels.
  modport master (
    output din, en, fsync,
    input  a, b, c, d, frame_vld, locked, sync_err, slot
`ifdef DEMUX_PARITY_EN
    , input par_err
`endif
  );

  modport slave (
    input  din, en, fsync,
    output a, b, c, d, frame_vld, locked, sync_err, slot
`ifdef DEMUX_PARITY_EN
    , output par_err
`endif
  );
endinterface

// File: rtl/tdm_demux41.sv
// TDM 1:4 demultiplexer with fsync-based frame alignment (HUNT/CHECK/LOCKED).
// Optional macro DEMUX_PARITY_EN adds a 5th even-parity slot and par_err.
module tdm_demux41 #(
  parameter int WIDTH       = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst,
  tdm_demux41_if.slave       bus
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

`ifdef DEMUX_PARITY_EN
  localparam logic [2:0] LAST_SLOT = 3'd4;
`else
  localparam logic [2:0] LAST_SLOT = 3'd3;
`endif
  localparam logic [3:0] LOCK_CNT = 4'(LOCK_FRAMES);

  state_t           state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q [4];
  logic [WIDTH-1:0] sh_d [4];
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             frame_vld_q, frame_vld_d;
  logic             sync_err_q, sync_err_d;
`ifdef DEMUX_PARITY_EN
  logic             par_err_q, par_err_d;
  logic [WIDTH-1:0] par_calc;
`endif

  logic [2:0] slot_next;
  logic       at_slot0;
  logic       misaligned;

  assign slot_next  = (slot_q == LAST_SLOT) ? 3'd0 : slot_q + 3'd1;
  assign at_slot0   = (slot_q == 3'd0);
  // Alignment holds only when fsync coincides exactly with slot 0.
  assign misaligned = (at_slot0 != bus.fsync);

`ifdef DEMUX_PARITY_EN
  assign par_calc = sh_q[0] ^ sh_q[1] ^ sh_q[2] ^ sh_q[3];
`endif

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    frame_vld_d = 1'b0;
    sync_err_d  = 1'b0;
`ifdef DEMUX_PARITY_EN
    par_err_d   = 1'b0;
`endif

    if (bus.en) begin
      unique case (state_q)
        HUNT: begin
          if (bus.fsync) begin
            sh_d[0] = bus.din;
            slot_d  = 3'd1;
            cnt_d   = 4'd0;
            state_d = CHECK;
          end
        end

        CHECK: begin
          if (misaligned) begin
            state_d = HUNT;
            slot_d  = 3'd0;
          end else begin
            if (slot_q < 3'd4) begin
              sh_d[slot_q[1:0]] = bus.din;
            end
            slot_d = slot_next;
            if (at_slot0) begin
              cnt_d = cnt_q + 4'd1;
              if (cnt_q + 4'd1 == LOCK_CNT) begin
                state_d = LOCKED;
              end
            end
          end
        end

        LOCKED: begin
          if (misaligned) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
            slot_d     = 3'd0;
          end else begin
            if (slot_q < 3'd4) begin
              sh_d[slot_q[1:0]] = bus.din;
            end
            slot_d = slot_next;
            if (slot_q == LAST_SLOT) begin
`ifdef DEMUX_PARITY_EN
              // Commit only frames whose parity slot agrees with the data.
              if (bus.din == par_calc) begin
                a_d         = sh_q[0];
                b_d         = sh_q[1];
                c_d         = sh_q[2];
                d_d         = sh_q[3];
                frame_vld_d = 1'b1;
              end else begin
                par_err_d = 1'b1;
              end
`else
              a_d         = sh_q[0];
              b_d         = sh_q[1];
              c_d         = sh_q[2];
              d_d         = bus.din;
              frame_vld_d = 1'b1;
`endif
            end
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      slot_q      <= 3'd0;
      cnt_q       <= 4'd0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      frame_vld_q <= 1'b0;
      sync_err_q  <= 1'b0;
`ifdef DEMUX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      for (int i = 0; i < 4; i++) begin
        sh_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      frame_vld_q <= frame_vld_d;
      sync_err_q  <= sync_err_d;
`ifdef DEMUX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
      for (int i = 0; i < 4; i++) begin
        sh_q[i] <= sh_d[i];
      end
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.c         = c_q;
  assign bus.d         = d_q;
  assign bus.frame_vld = frame_vld_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.sync_err  = sync_err_q;
  assign bus.slot      = slot_q;
`ifdef DEMUX_PARITY_EN
  assign bus.par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux41.sv
// Directed self-checking bench for tdm_demux41 (WIDTH=1, LOCK_FRAMES=2).
// Covers the DEMUX_PARITY_EN build when that macro is defined.
module tb_tdm_demux41;

`ifdef DEMUX_PARITY_EN
  localparam int LAST = 4;
`else
  localparam int LAST = 3;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  tdm_demux41_if #(.WIDTH(1)) bus ();

  tdm_demux41 #(.WIDTH(1), .LOCK_FRAMES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one clock of inputs, then settle just past the edge for sampling.
  task automatic applyStimulus(input logic r, input logic e, input logic f, input logic dv);
    rst       = r;
    bus.en    = e;
    bus.fsync = f;
    bus.din   = dv;
    @(posedge clk);
    #1;
  endtask

  // pat is {a,b,c,d}; slot 4 carries parity, optionally corrupted.
  task automatic sendSlots(input logic [3:0] pat, input int first, input int last, input logic par_flip);
    logic bit_v;
    for (int k = first; k <= last; k++) begin
      if (k < 4) bit_v = pat[3-k];
      else       bit_v = (^pat) ^ par_flip;
      applyStimulus(1'b0, 1'b1, (k == 0), bit_v);
    end
  endtask

  task automatic sendFrame(input logic [3:0] pat);
    sendSlots(pat, 0, LAST, 1'b0);
  endtask

  function automatic logic [7:0] abcd();
    return {4'b0, bus.a, bus.b, bus.c, bus.d};
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.fsync   = 1'b0;
    bus.din     = 1'b0;

    // Reset with live strobe and data
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_abcd", abcd(), 8'h0);
    checkOutput("rst_vld", {7'b0, bus.frame_vld}, 8'h0);
    checkOutput("rst_locked", {7'b0, bus.locked}, 8'h0);
    checkOutput("rst_syncerr", {7'b0, bus.sync_err}, 8'h0);
    checkOutput("rst_slot", {5'b0, bus.slot}, 8'h0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("hunt_slot", {5'b0, bus.slot}, 8'h0);

    // Acquire lock
    sendFrame(4'b1000);
    checkOutput("chk1_locked", {7'b0, bus.locked}, 8'h0);
    checkOutput("chk1_vld", {7'b0, bus.frame_vld}, 8'h0);
    sendFrame(4'b0100);
    checkOutput("chk2_locked", {7'b0, bus.locked}, 8'h0);
    checkOutput("chk2_abcd", abcd(), 8'h0);
    sendSlots(4'b0010, 0, 0, 1'b0);
    checkOutput("lock_rise", {7'b0, bus.locked}, 8'h1);
    sendSlots(4'b0010, 1, LAST - 1, 1'b0);
    checkOutput("f3_pre_vld", {7'b0, bus.frame_vld}, 8'h0);
    checkOutput("f3_pre_abcd", abcd(), 8'h0);
    sendSlots(4'b0010, LAST, LAST, 1'b0);
    checkOutput("f3_vld", {7'b0, bus.frame_vld}, 8'h1);
    checkOutput("f3_abcd", abcd(), 8'h2);
    sendSlots(4'b0001, 0, 0, 1'b0);
    checkOutput("f4_vld_drop", {7'b0, bus.frame_vld}, 8'h0);
    sendSlots(4'b0001, 1, LAST, 1'b0);
    checkOutput("f4_abcd", abcd(), 8'h1);
    checkOutput("f4_vld", {7'b0, bus.frame_vld}, 8'h1);
    sendFrame(4'b1000);
    checkOutput("f5_abcd", abcd(), 8'h8);

    // en gaps mid-frame with din/fsync toggling
    sendSlots(4'b0110, 0, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("gap_slot", {5'b0, bus.slot}, 8'h2);
    checkOutput("gap_abcd", abcd(), 8'h8);
    checkOutput("gap_locked", {7'b0, bus.locked}, 8'h1);
    checkOutput("gap_syncerr", {7'b0, bus.sync_err}, 8'h0);
    sendSlots(4'b0110, 2, LAST, 1'b0);
    checkOutput("gap_commit", abcd(), 8'h6);
    checkOutput("gap_vld", {7'b0, bus.frame_vld}, 8'h1);

    // Misaligned fsync at slot 2
    sendSlots(4'b0101, 0, 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("mis_syncerr", {7'b0, bus.sync_err}, 8'h1);
    checkOutput("mis_locked", {7'b0, bus.locked}, 8'h0);
    checkOutput("mis_vld", {7'b0, bus.frame_vld}, 8'h0);
    checkOutput("mis_abcd", abcd(), 8'h6);
    checkOutput("mis_slot", {5'b0, bus.slot}, 8'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("mis_pulse_end", {7'b0, bus.sync_err}, 8'h0);
    checkOutput("mis_hunt_slot", {5'b0, bus.slot}, 8'h0);
    sendFrame(4'b1001);
    checkOutput("relock1_locked", {7'b0, bus.locked}, 8'h0);
    sendFrame(4'b1001);
    checkOutput("relock2_locked", {7'b0, bus.locked}, 8'h0);
    checkOutput("relock2_abcd", abcd(), 8'h6);
    sendSlots(4'b0011, 0, 0, 1'b0);
    checkOutput("relock_rise", {7'b0, bus.locked}, 8'h1);
    sendSlots(4'b0011, 1, LAST, 1'b0);
    checkOutput("relock_abcd", abcd(), 8'h3);

    // Reset mid-frame
    sendSlots(4'b1100, 0, 1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("midrst_abcd", abcd(), 8'h0);
    checkOutput("midrst_locked", {7'b0, bus.locked}, 8'h0);
    checkOutput("midrst_slot", {5'b0, bus.slot}, 8'h0);
    sendSlots(4'b1100, 2, LAST, 1'b0);
    checkOutput("midrst_vld", {7'b0, bus.frame_vld}, 8'h0);
    checkOutput("midrst_hunt", {5'b0, bus.slot}, 8'h0);

    // Missing fsync at slot 0 while in CHECK drops to HUNT silently
    sendFrame(4'b1000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("chk_drop_syncerr", {7'b0, bus.sync_err}, 8'h0);
    checkOutput("chk_drop_slot", {5'b0, bus.slot}, 8'h0);
    sendSlots(4'b1000, 1, 1, 1'b0);
    checkOutput("chk_drop_hold", {5'b0, bus.slot}, 8'h0);

`ifdef DEMUX_PARITY_EN
    sendFrame(4'b1010);
    sendFrame(4'b1010);
    sendSlots(4'b1100, 0, 4, 1'b0);
    checkOutput("par_ok_abcd", abcd(), 8'hC);
    checkOutput("par_ok_vld", {7'b0, bus.frame_vld}, 8'h1);
    checkOutput("par_ok_err", {7'b0, bus.par_err}, 8'h0);
    sendSlots(4'b1100, 0, 4, 1'b1);
    checkOutput("par_bad_err", {7'b0, bus.par_err}, 8'h1);
    checkOutput("par_bad_vld", {7'b0, bus.frame_vld}, 8'h0);
    checkOutput("par_bad_locked", {7'b0, bus.locked}, 8'h1);
    sendSlots(4'b0011, 0, 4, 1'b1);
    checkOutput("par_bad2_abcd", abcd(), 8'hC);
    checkOutput("par_bad2_err", {7'b0, bus.par_err}, 8'h1);
    sendSlots(4'b0011, 0, 4, 1'b0);
    checkOutput("par_ok2_abcd", abcd(), 8'h3);
    checkOutput("par_ok2_err", {7'b0, bus.par_err}, 8'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
